// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA field positions, opcode classes and loader states
package isa_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_ILL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE
    } ld_state_t;

    localparam logic [3:0] COND_AL_DEF = 4'hE;

    localparam int COND_LSB   = 28;
    localparam int OP_LSB     = 26;
    localparam int IMM_BIT    = 25;
    localparam int CMD_LSB    = 21;
    localparam int L_BIT      = 20;
    localparam int RN_LSB     = 16;
    localparam int RD_LSB     = 12;
    localparam int MEMCLS_LSB = 23;
    localparam int BRCLS_LSB  = 24;

    // Class tags that let the decoder tell memory and branch words apart from DP
    localparam logic [1:0] MEM_CLASS = 2'b11;
    localparam logic [1:0] BR_CLASS  = 2'b10;

endpackage

// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - combinational packing of instruction fields into a 32-bit word
module instr_packer
    import isa_pkg::*;
#(
    parameter logic [3:0] COND = COND_AL_DEF
) (
    input  logic [1:0]  op,
    input  logic        imm,
    input  logic        mem,
    input  logic [3:0]  cmd,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [11:0] src2,
    input  logic [23:0] br_off,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        word[COND_LSB +: 4] = COND;
        word[OP_LSB +: 2]   = op;
        case (op_t'(op))
            OP_DP: begin
                word[IMM_BIT]       = imm;
                word[CMD_LSB +: 4]  = cmd;
                word[RN_LSB +: 4]   = rn;
                word[RD_LSB +: 4]   = rd;
                word[11:0]          = src2;
            end
            OP_MEM: begin
                word[MEMCLS_LSB +: 2] = MEM_CLASS;
                word[L_BIT]           = mem;
                word[RN_LSB +: 4]     = rn;
                word[RD_LSB +: 4]     = rd;
                word[11:0]            = src2;
            end
            OP_BR: begin
                word[BRCLS_LSB +: 2] = BR_CLASS;
                word[23:0]           = br_off;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - accepts field tuples and writes encoded words into instruction memory
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int                ADDR_W    = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [3:0]        COND_AL   = COND_AL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic              in_imm,
    input  logic              in_mem,
    input  logic [3:0]        in_cmd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [11:0]       in_src2,
    input  logic [23:0]       in_br_off,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic [31:0]       packed_word;

    instr_packer #(
        .COND (COND_AL)
    ) u_packer (
        .op     (in_op),
        .imm    (in_imm),
        .mem    (in_mem),
        .cmd    (in_cmd),
        .rn     (in_rn),
        .rd     (in_rd),
        .src2   (in_src2),
        .br_off (in_br_off),
        .word   (packed_word)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        full_d  = full_q;
        err_d   = err_q;
        // start outranks everything, including a tuple offered in the same cycle
        if (start) begin
            state_d = S_ACCEPT;
            addr_d  = BASE_ADDR;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_ACCEPT: begin
                    if (in_valid) begin
                        if (op_t'(in_op) == OP_ILL) begin
                            err_d = 1'b1;
                            if (in_last) state_d = S_DONE;
                        end else begin
                            wdata_d = packed_word;
                            last_d  = in_last;
                            state_d = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W+1)'(1);
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (addr_q == ADDR_MAX) begin
                        full_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // An abort landing in the write cycle must suppress that write
    assign imem_we    = (state_q == S_WRITE) && !start;
    assign in_ready   = (state_q == S_ACCEPT);
    assign done       = (state_q == S_DONE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign full       = full_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic start_f = 1'b0;
    logic valid_f = 1'b0;
    logic [1:0]  f_op = '0;
    logic        f_imm = 1'b0;
    logic        f_mem = 1'b0;
    logic [3:0]  f_cmd = '0;
    logic [3:0]  f_rn = '0;
    logic [3:0]  f_rd = '0;
    logic [11:0] f_src2 = '0;
    logic [23:0] f_br = '0;
    logic        f_last = 1'b0;

    logic        in_ready, imem_we, done, full, err;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  word_count;

    logic        ready_f, we_f, done_f, full_f, err_f;
    logic [1:0]  addr_f;
    logic [31:0] wdata_f;
    logic [2:0]  count_f;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    instr_encoder_loader u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(f_op), .in_imm(f_imm), .in_mem(f_mem), .in_cmd(f_cmd), .in_rn(f_rn),
        .in_rd(f_rd), .in_src2(f_src2), .in_br_off(f_br), .in_last(f_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .done(done), .full(full), .err(err)
    );

    instr_encoder_loader #(.ADDR_W(2)) u_full (
        .clk(clk), .rst(rst), .start(start_f), .in_valid(valid_f), .in_ready(ready_f),
        .in_op(f_op), .in_imm(f_imm), .in_mem(f_mem), .in_cmd(f_cmd), .in_rn(f_rn),
        .in_rd(f_rd), .in_src2(f_src2), .in_br_off(f_br), .in_last(f_last),
        .imem_we(we_f), .imem_addr(addr_f), .imem_wdata(wdata_f),
        .word_count(count_f), .done(done_f), .full(full_f), .err(err_f)
    );

    logic [1:0]  rt_op;
    logic        rt_imm, rt_mem;
    logic [3:0]  rt_cmd, rt_rn, rt_rd;
    logic [11:0] rt_src2;
    logic [23:0] rt_br;
    logic [31:0] rt_word;

    instr_packer u_ref_pack (
        .op(rt_op), .imm(rt_imm), .mem(rt_mem), .cmd(rt_cmd), .rn(rt_rn),
        .rd(rt_rd), .src2(rt_src2), .br_off(rt_br), .word(rt_word)
    );

    int          wr_cnt = 0;
    int          wr_addr [0:255];
    logic [31:0] wr_data [0:255];
    int          fw_cnt = 0;
    int          fw_addr [0:15];
    int          hs_f = 0;

    always @(negedge clk) begin
        if (imem_we && wr_cnt < 256) begin
            wr_addr[wr_cnt] = int'(imem_addr);
            wr_data[wr_cnt] = imem_wdata;
            wr_cnt++;
        end
        if (we_f && fw_cnt < 16) begin
            fw_addr[fw_cnt] = int'(addr_f);
            fw_cnt++;
        end
        if (valid_f && ready_f) hs_f++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic set_fields(input logic [1:0] op, input logic imm, input logic mem,
                              input logic [3:0] cmd, input logic [3:0] rn, input logic [3:0] rd,
                              input logic [11:0] src2, input logic [23:0] br, input logic last);
        f_op = op; f_imm = imm; f_mem = mem; f_cmd = cmd; f_rn = rn; f_rd = rd;
        f_src2 = src2; f_br = br; f_last = last;
    endtask

    // Offers one tuple and returns at posedge+1 right after the accepting edge
    task automatic send(input logic [1:0] op, input logic imm, input logic mem,
                        input logic [3:0] cmd, input logic [3:0] rn, input logic [3:0] rd,
                        input logic [11:0] src2, input logic [23:0] br, input logic last);
        logic acc;
        acc = 1'b0;
        @(posedge clk); #1;
        set_fields(op, imm, mem, cmd, rn, rd, src2, br, last);
        in_valid = 1'b1;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("hs_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_set", 32'(done), 32'd1);
    endtask

    int base;

    initial begin
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_flags", {29'd0, done, full, err}, 32'd0);

        base = wr_cnt;
        pulse_start();
        send(2'b00, 1'b1, 1'b0, 4'd4, 4'd1, 4'd2, 12'h005, 24'd0, 1'b1);
        @(negedge clk);
        check("dp_lat_we", 32'(imem_we), 32'd1);
        check("dp_lat_addr", 32'(imem_addr), 32'd0);
        wait_done();
        check("dp_nwr", 32'(wr_cnt - base), 32'd1);
        check("dp_addr", 32'(wr_addr[base]), 32'd0);
        check("dp_word", wr_data[base], 32'hE2812005);
        check("dp_count", 32'(word_count), 32'd1);
        check("dp_ready", 32'(in_ready), 32'd0);

        base = wr_cnt;
        pulse_start();
        send(2'b01, 1'b0, 1'b0, 4'd0, 4'd3, 4'd4, 12'h008, 24'd0, 1'b0);
        send(2'b01, 1'b0, 1'b1, 4'd0, 4'd3, 4'd4, 12'h008, 24'd0, 1'b1);
        wait_done();
        check("mem_nwr", 32'(wr_cnt - base), 32'd2);
        check("mem_a0", 32'(wr_addr[base]), 32'd0);
        check("mem_w0", wr_data[base], 32'hE5834008);
        check("mem_a1", 32'(wr_addr[base+1]), 32'd1);
        check("mem_w1", wr_data[base+1], 32'hE5934008);
        check("mem_count", 32'(word_count), 32'd2);

        base = wr_cnt;
        pulse_start();
        send(2'b10, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 12'h000, 24'hFFFFFE, 1'b1);
        wait_done();
        check("br_nwr", 32'(wr_cnt - base), 32'd1);
        check("br_word", wr_data[base], 32'hEAFFFFFE);

        base = wr_cnt;
        pulse_start();
        send(2'b00, 1'b0, 1'b0, 4'hD, 4'd0, 4'd5, 12'h0FF, 24'd0, 1'b0);
        send(2'b11, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 12'hFFF, 24'd0, 1'b0);
        send(2'b00, 1'b1, 1'b0, 4'd2, 4'd7, 4'd7, 12'h001, 24'd0, 1'b1);
        wait_done();
        check("ill_err", 32'(err), 32'd1);
        check("ill_nwr", 32'(wr_cnt - base), 32'd2);
        check("ill_a0", 32'(wr_addr[base]), 32'd0);
        check("ill_w0", wr_data[base], 32'hE1A050FF);
        check("ill_a1", 32'(wr_addr[base+1]), 32'd1);
        check("ill_w1", wr_data[base+1], 32'hE2477001);
        check("ill_count", 32'(word_count), 32'd2);

        base = wr_cnt;
        pulse_start();
        send(2'b00, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 12'h001, 24'd0, 1'b0);
        start = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("abort_we", 32'(imem_we), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_addr", 32'(imem_addr), 32'd0);
        check("abort_count", 32'(word_count), 32'd0);
        check("abort_flags", {29'd0, done, full, err}, 32'd0);
        check("abort_nwr", 32'(wr_cnt - base), 32'd0);

        base = wr_cnt;
        send(2'b00, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 12'h001, 24'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstw_we", 32'(imem_we), 32'd0);
        repeat (3) @(negedge clk);
        check("rstw_nwr", 32'(wr_cnt - base), 32'd1);
        check("rstw_ready", 32'(in_ready), 32'd0);

        @(posedge clk); #1 start_f = 1'b1;
        @(posedge clk); #1 start_f = 1'b0;
        set_fields(2'b00, 1'b0, 1'b0, 4'd3, 4'd2, 4'd1, 12'h010, 24'd0, 1'b0);
        valid_f = 1'b1;
        repeat (12) @(posedge clk);
        #1 valid_f = 1'b0;
        @(negedge clk);
        check("full_nwr", 32'(fw_cnt), 32'd4);
        for (int i = 0; i < 4; i++) check("full_addr", 32'(fw_addr[i]), 32'(i));
        check("full_hs", 32'(hs_f), 32'd4);
        check("full_flag", 32'(full_f), 32'd1);
        check("full_done", 32'(done_f), 32'd1);
        check("full_ready", 32'(ready_f), 32'd0);
        check("full_count", 32'(count_f), 32'd4);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] obs, exp;
            rt_op   = 2'($urandom_range(0, 2));
            rt_imm  = 1'($urandom);
            rt_mem  = 1'($urandom);
            rt_cmd  = 4'($urandom);
            rt_rn   = 4'($urandom);
            rt_rd   = 4'($urandom);
            rt_src2 = 12'($urandom);
            rt_br   = 24'($urandom);
            #1;
            obs = {rt_word[31:28], rt_word[27:26],
                   (rt_word[27:26] == 2'b00) ? rt_word[25] : 1'b0,
                   (rt_word[27:26] == 2'b01) ? rt_word[20] : 1'b0};
            exp = {4'hE, rt_op,
                   (rt_op == 2'b00) ? rt_imm : 1'b0,
                   (rt_op == 2'b01) ? rt_mem : 1'b0};
            check("roundtrip", 32'(obs), 32'(exp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
